// File: rtl/sync_fifo_downsizer.sv
// Width converter on the FIFO read side: accepts one wide word and replays it
// as RATIO narrow beats, reloading on the last beat so a full-rate sink sees no gap.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module sync_fifo_downsizer #(
   parameter int    DATA_WIDTH = `DATA_WIDTH,
   parameter int    OUT_WIDTH  = 8,
   parameter string MSB_FIRST  = "FALSE",
   parameter int    RATIO      = DATA_WIDTH / OUT_WIDTH,
   parameter int    CNT_WIDTH  = $clog2(RATIO)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid_s,
   input  logic [DATA_WIDTH-1:0] i_datain,
   output logic                  o_ready_s,
   output logic                  o_valid_m,
   output logic [OUT_WIDTH-1:0]  o_dataout,
   input  logic                  i_ready_m,
   output logic                  o_last,
   output logic                  o_busy
);

   localparam logic [0:0]           ST_IDLE  = 1'b0;
   localparam logic [0:0]           ST_SHIFT = 1'b1;
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(RATIO - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam bit                   MSB_SEL  = (MSB_FIRST == "TRUE");

   if (((DATA_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2) ||
       ((MSB_FIRST != "TRUE") && (MSB_FIRST != "FALSE"))) begin : g_bad_cfg
      $error("sync_fifo_downsizer: illegal DATA_WIDTH/OUT_WIDTH/MSB_FIRST combination");
   end

   logic [0:0]            r_state;
   logic [DATA_WIDTH-1:0] r_hold;
   logic [CNT_WIDTH-1:0]  r_cnt;

   logic                  w_shift;
   logic                  w_last;
   logic                  w_word_xfer;
   logic                  w_beat_xfer;
   logic [31:0]           w_sel;
   logic [DATA_WIDTH-1:0] w_shifted;

   assign w_shift     = (r_state == ST_SHIFT);
   assign w_last      = w_shift & (r_cnt == LAST_CNT);
   assign o_ready_s   = i_rst_n & (~w_shift | (w_last & i_ready_m));
   assign w_word_xfer = i_valid_s & o_ready_s;
   assign w_beat_xfer = w_shift & i_ready_m;

   assign o_valid_m   = w_shift;
   assign o_busy      = w_shift;
   assign o_last      = w_last;

   // Beat index into the held word; MSB-first walks the slices downward.
   assign w_sel       = MSB_SEL ? (32'(RATIO - 1) - 32'(r_cnt)) : 32'(r_cnt);
   assign w_shifted   = r_hold >> (w_sel * 32'(OUT_WIDTH));
   assign o_dataout   = w_shift ? w_shifted[OUT_WIDTH-1:0] : {OUT_WIDTH{1'b0}};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_hold  <= {DATA_WIDTH{1'b0}};
         r_cnt   <= CNT_ZERO;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_word_xfer) begin
                  r_hold  <= i_datain;
                  r_cnt   <= CNT_ZERO;
                  r_state <= ST_SHIFT;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (w_beat_xfer) begin
                  if (r_cnt != LAST_CNT) begin
                     r_cnt <= r_cnt + CNT_ONE;
                  end else if (w_word_xfer) begin
                     // Reload on the final beat keeps the output stream gap-free.
                     r_hold <= i_datain;
                     r_cnt  <= CNT_ZERO;
                  end else begin
                     r_cnt   <= CNT_ZERO;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_state <= ST_SHIFT;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sync_fifo_downsizer.sv
// Directed bench for sync_fifo_downsizer: LSB/MSB ordering, back-to-back words,
// random stalls against a byte scoreboard, mid-word reset and a RATIO=3 build.
`timescale 1ns/1ps

module tb_sync_fifo_downsizer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 32/8 LSB-first instance
   logic        a_valid_s = 1'b0, a_ready_m = 1'b0;
   logic [31:0] a_datain  = 32'h0;
   logic        a_ready_s, a_valid_m, a_last, a_busy;
   logic [7:0]  a_dataout;
   // 32/8 MSB-first instance
   logic        m_valid_s = 1'b0, m_ready_m = 1'b0;
   logic [31:0] m_datain  = 32'h0;
   logic        m_ready_s, m_valid_m, m_last, m_busy;
   logic [7:0]  m_dataout;
   // 24/8 instance (RATIO=3)
   logic        t_valid_s = 1'b0, t_ready_m = 1'b0;
   logic [23:0] t_datain  = 24'h0;
   logic        t_ready_s, t_valid_m, t_last, t_busy;
   logic [7:0]  t_dataout;

   sync_fifo_downsizer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST("FALSE")) a_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid_s(a_valid_s), .i_datain(a_datain),
      .o_ready_s(a_ready_s), .o_valid_m(a_valid_m), .o_dataout(a_dataout),
      .i_ready_m(a_ready_m), .o_last(a_last), .o_busy(a_busy));

   sync_fifo_downsizer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST("TRUE")) m_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid_s(m_valid_s), .i_datain(m_datain),
      .o_ready_s(m_ready_s), .o_valid_m(m_valid_m), .o_dataout(m_dataout),
      .i_ready_m(m_ready_m), .o_last(m_last), .o_busy(m_busy));

   sync_fifo_downsizer #(.DATA_WIDTH(24), .OUT_WIDTH(8), .MSB_FIRST("FALSE")) t_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid_s(t_valid_s), .i_datain(t_datain),
      .o_ready_s(t_ready_s), .o_valid_m(t_valid_m), .o_dataout(t_dataout),
      .i_ready_m(t_ready_m), .o_last(t_last), .o_busy(t_busy));

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_q[$];
   logic [7:0] exp_b;
   logic [31:0] word;
   logic [7:0] lsb_seq [4];
   logic [7:0] msb_seq [4];
   logic [7:0] r3_seq  [6];

   initial begin
      lsb_seq = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      msb_seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      r3_seq  = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};

      // ---- reset state ----
      #2;
      chk("rst_valid", 32'(a_valid_m), 32'd0);
      chk("rst_ready", 32'(a_ready_s), 32'd0);
      chk("rst_busy",  32'(a_busy),    32'd0);
      chk("rst_last",  32'(a_last),    32'd0);
      chk("rst_data",  32'(a_dataout), 32'h00);
      tick();
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 32'(a_ready_s), 32'd1);
      chk("post_rst_valid", 32'(a_valid_m), 32'd0);

      // ---- single word, LSB first ----
      a_valid_s = 1'b1; a_datain = 32'hA1B2C3D4; a_ready_m = 1'b1;
      #1;
      chk("w1_ready_idle", 32'(a_ready_s), 32'd1);
      tick();
      a_valid_s = 1'b0; a_datain = 32'hDEADBEEF;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("w1_valid", 32'(a_valid_m), 32'd1);
         chk("w1_data",  32'(a_dataout), 32'(lsb_seq[i]));
         chk("w1_last",  32'(a_last),    32'(i == 3));
         chk("w1_ready", 32'(a_ready_s), 32'(i == 3));
         chk("w1_busy",  32'(a_busy),    32'd1);
         tick();
         #1;
      end
      chk("w1_idle_valid", 32'(a_valid_m), 32'd0);

      // ---- back-to-back words ----
      a_valid_s = 1'b1; a_datain = 32'h03020100;
      #1;
      tick();
      a_datain = 32'h07060504;
      #1;
      for (int i = 0; i < 8; i++) begin
         chk("b2b_valid", 32'(a_valid_m), 32'd1);
         chk("b2b_data",  32'(a_dataout), 32'(i));
         chk("b2b_ready", 32'(a_ready_s), 32'((i == 3) || (i == 7)));
         tick();
         if (i == 3) a_valid_s = 1'b0;
         #1;
      end
      chk("b2b_idle_valid", 32'(a_valid_m), 32'd0);

      // ---- random stalls, 100 words ----
      begin
         int words_left = 100;
         int beats_rx   = 0;
         int cycles     = 0;
         logic prev_stall = 1'b0;
         logic [7:0] prev_data = 8'h00;
         logic prev_last = 1'b0;
         logic acc;
         while (beats_rx < 400 && cycles < 3000) begin
            a_ready_m = 1'($urandom_range(0, 1));
            if (!a_valid_s && words_left > 0) begin
               word = $urandom();
               a_datain = word;
               a_valid_s = 1'b1;
               for (int k = 0; k < 4; k++) exp_q.push_back(word[k*8 +: 8]);
            end
            #1;
            if (prev_stall) begin
               chk("stall_valid", 32'(a_valid_m), 32'd1);
               chk("stall_data",  32'(a_dataout), 32'(prev_data));
               chk("stall_last",  32'(a_last),    32'(prev_last));
            end
            if (a_valid_m && a_ready_m) begin
               if (exp_q.size() == 0) begin
                  chk("rand_extra_beat", 32'(a_dataout), 32'hFFFF_FFFF);
               end else begin
                  exp_b = exp_q.pop_front();
                  chk("rand_data", 32'(a_dataout), 32'(exp_b));
                  chk("rand_last", 32'(a_last), 32'(exp_q.size() % 4 == 0));
               end
               beats_rx++;
            end
            prev_stall = a_valid_m & ~a_ready_m;
            prev_data  = a_dataout;
            prev_last  = a_last;
            acc = a_valid_s & a_ready_s;
            tick();
            cycles++;
            if (acc) begin
               a_valid_s = 1'b0;
               words_left--;
            end
         end
         chk("rand_beats_rx", 32'(beats_rx), 32'd400);
         a_ready_m = 1'b1;
         tick();
         #1;
         chk("rand_drained", 32'(a_valid_m), 32'd0);
      end

      // ---- reset in the middle of a word ----
      a_valid_s = 1'b1; a_datain = 32'h11223344; a_ready_m = 1'b1;
      tick();
      a_valid_s = 1'b0;
      #1;
      chk("mid_b0", 32'(a_dataout), 32'h44);
      tick();
      #1;
      chk("mid_b1", 32'(a_dataout), 32'h33);
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(a_valid_m), 32'd0);
      chk("mid_rst_ready", 32'(a_ready_s), 32'd0);
      chk("mid_rst_data",  32'(a_dataout), 32'h00);
      tick();
      rst_n = 1'b1;
      #1;
      chk("mid_rel_valid", 32'(a_valid_m), 32'd0);
      a_valid_s = 1'b1; a_datain = 32'h55667788;
      tick();
      a_valid_s = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("mid_next_valid", 32'(a_valid_m), 32'd1);
         chk("mid_next_data",  32'(a_dataout), 32'h88 - 32'(i * 8'h11));
         tick();
         #1;
      end
      chk("mid_next_idle", 32'(a_valid_m), 32'd0);

      // ---- MSB first ----
      m_valid_s = 1'b1; m_datain = 32'hA1B2C3D4; m_ready_m = 1'b1;
      tick();
      m_valid_s = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("msb_valid", 32'(m_valid_m), 32'd1);
         chk("msb_data",  32'(m_dataout), 32'(msb_seq[i]));
         chk("msb_last",  32'(m_last),    32'(i == 3));
         tick();
         #1;
      end
      chk("msb_idle", 32'(m_valid_m), 32'd0);

      // ---- RATIO = 3, back-to-back ----
      t_valid_s = 1'b1; t_datain = 24'hCCBBAA; t_ready_m = 1'b1;
      tick();
      t_datain = 24'h332211;
      #1;
      for (int i = 0; i < 6; i++) begin
         chk("r3_valid", 32'(t_valid_m), 32'd1);
         chk("r3_data",  32'(t_dataout), 32'(r3_seq[i]));
         chk("r3_last",  32'(t_last),    32'((i == 2) || (i == 5)));
         chk("r3_cnt_max", 32'(t_dut.r_cnt <= 2'd2), 32'd1);
         tick();
         if (i == 2) t_valid_s = 1'b0;
         #1;
      end
      chk("r3_idle", 32'(t_valid_m), 32'd0);
      chk("r3_cnt_idle", 32'(t_dut.r_cnt <= 2'd2), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
